dma_write_engine: RTL

Benchmark DMA write initiator, the transmit-side counterpart of `dma_read_engine`. On a software start pulse it splits a host-memory region into chunk-sized write commands on `m_axis_dma_write_cmd`. After each command it streams that command's payload, a deterministic counting pattern, on `m_axis_dma_write_data`. It sits between the control/status register file and the DMA write channels, and reports progress and elapsed cycles for throughput measurement.

---
 rtl/dma_write_engine_if.sv | 26 ++
 rtl/dma_write_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_engine_if.sv
// Handshake bundles for the DMA write engine: write-command channel and write-data stream.

interface axis_mem_cmd_if;
  logic        valid;
  logic        ready;
  logic [63:0] address;
  logic [31:0] length;

  modport master (output valid, output address, output length, input ready);
  modport slave  (input valid, input address, input length, output ready);
endinterface

interface axi_stream_if #(
  parameter int unsigned DATA_BYTES = 64
);
  localparam int unsigned DATA_W = DATA_BYTES * 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     data;
  logic [DATA_BYTES-1:0] keep;
  logic                  last;

  modport master (output valid, output data, output keep, output last, input ready);
  modport slave  (input valid, input data, input keep, input last, output ready);
endinterface

// File: rtl/dma_write_engine.sv
// DMA write initiator: splits a host region into chunk commands, streams a counting
// pattern per command, and reports commands/beats/elapsed cycles.

module dma_write_engine #(
  parameter int unsigned DATA_BYTES = 64
) (
  input  logic               clk,
  input  logic               rstn,
  axis_mem_cmd_if.master     m_axis_dma_write_cmd,
  axi_stream_if.master       m_axis_dma_write_data,
  input  logic [15:0][31:0]  control_reg,
  output logic [7:0][31:0]   status_reg
);

  localparam int unsigned DATA_W = DATA_BYTES * 8;
  localparam int unsigned WORDS  = DATA_BYTES / 4;
  localparam int unsigned OFS_W  = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t                state_q, state_d;
  logic                  start_prev_q;
  logic [63:0]           addr_q, addr_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [31:0]           chunk_q, chunk_d;
  logic [31:0]           seed_q, seed_d;
  logic [OFS_W-1:0]      cur_rem_q, cur_rem_d;
  logic [31:0]           beats_q, beats_d;
  logic [31:0]           beat_idx_q, beat_idx_d;
  logic [31:0]           cmds_q, cmds_d;
  logic [31:0]           beats_total_q, beats_total_d;
  logic [31:0]           elapsed_q, elapsed_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [63:0]           cmd_addr_q, cmd_addr_d;
  logic [31:0]           cmd_len_q, cmd_len_d;
  logic                  data_valid_q, data_valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_BYTES-1:0] keep_q, keep_d;
  logic                  last_q, last_d;
  logic                  start_edge_c;
  logic                  next_last_c;
  logic                  first_last_c;
  logic                  unused_ctrl;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    min32 = (a < b) ? a : b;
  endfunction

  // Partial final beat keeps only the bytes that belong to the command.
  function automatic logic [DATA_BYTES-1:0] keep_for(input logic [OFS_W-1:0] rem,
                                                     input logic final_beat);
    if (final_beat && rem != '0) keep_for = (DATA_BYTES'(1) << rem) - DATA_BYTES'(1);
    else                         keep_for = '1;
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input logic [31:0] w);
    beat_data = {WORDS{w}};
  endfunction

  assign start_edge_c = control_reg[7][1] & ~start_prev_q;
  assign first_last_c = (cmd_len_q <= 32'(DATA_BYTES));
  assign next_last_c  = (beat_idx_q + 32'd2 == beats_q);
  assign unused_ctrl  = ^{control_reg[15:8], control_reg[7][31:2], control_reg[7][0],
                          control_reg[3:2]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      chunk_q       <= '0;
      seed_q        <= '0;
      cur_rem_q     <= '0;
      beats_q       <= '0;
      beat_idx_q    <= '0;
      cmds_q        <= '0;
      beats_total_q <= '0;
      elapsed_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      data_valid_q  <= 1'b0;
      data_q        <= '0;
      keep_q        <= '0;
      last_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= control_reg[7][1];
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      chunk_q       <= chunk_d;
      seed_q        <= seed_d;
      cur_rem_q     <= cur_rem_d;
      beats_q       <= beats_d;
      beat_idx_q    <= beat_idx_d;
      cmds_q        <= cmds_d;
      beats_total_q <= beats_total_d;
      elapsed_q     <= elapsed_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      data_valid_q  <= data_valid_d;
      data_q        <= data_d;
      keep_q        <= keep_d;
      last_q        <= last_d;
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle ahead.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    chunk_d       = chunk_q;
    seed_d        = seed_q;
    cur_rem_d     = cur_rem_q;
    beats_d       = beats_q;
    beat_idx_d    = beat_idx_q;
    cmds_d        = cmds_q;
    beats_total_d = beats_total_q;
    elapsed_d     = elapsed_q;
    busy_d        = busy_q;
    done_d        = done_q;
    cmd_valid_d   = cmd_valid_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    data_valid_d  = data_valid_q;
    data_d        = data_q;
    keep_d        = keep_q;
    last_d        = last_q;

    // Empty-transfer DONE visit is bookkeeping only, not transfer time.
    if (busy_q && state_q != DONE && elapsed_q != '1) elapsed_d = elapsed_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (start_edge_c) begin
          addr_d        = {control_reg[1], control_reg[0]};
          remaining_d   = control_reg[4];
          chunk_d       = control_reg[6];
          seed_d        = control_reg[5];
          cmds_d        = '0;
          beats_total_d = '0;
          elapsed_d     = '0;
          done_d        = 1'b0;
          busy_d        = 1'b1;
          if (control_reg[4] == '0 || control_reg[6] == '0) begin
            state_d = DONE;
          end else begin
            state_d     = CMD;
            cmd_valid_d = 1'b1;
            cmd_addr_d  = {control_reg[1], control_reg[0]};
            cmd_len_d   = min32(control_reg[6], control_reg[4]);
          end
        end
      end
      CMD: begin
        if (m_axis_dma_write_cmd.ready) begin
          cur_rem_d    = cmd_len_q[OFS_W-1:0];
          beats_d      = 32'((33'(cmd_len_q) + 33'(DATA_BYTES - 1)) >> OFS_W);
          beat_idx_d   = '0;
          addr_d       = addr_q + 64'(chunk_q);
          remaining_d  = remaining_q - cmd_len_q;
          cmds_d       = cmds_q + 32'd1;
          cmd_valid_d  = 1'b0;
          data_valid_d = 1'b1;
          data_d       = beat_data(seed_q + beats_total_q);
          last_d       = first_last_c;
          keep_d       = keep_for(cmd_len_q[OFS_W-1:0], first_last_c);
          state_d      = DATA;
        end
      end
      DATA: begin
        if (m_axis_dma_write_data.ready) begin
          beats_total_d = beats_total_q + 32'd1;
          beat_idx_d    = beat_idx_q + 32'd1;
          if (last_q) begin
            data_valid_d = 1'b0;
            data_d       = '0;
            keep_d       = '0;
            last_d       = 1'b0;
            if (remaining_q != '0) begin
              state_d     = CMD;
              cmd_valid_d = 1'b1;
              cmd_addr_d  = addr_q;
              cmd_len_d   = min32(chunk_q, remaining_q);
            end else begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            data_d = beat_data(seed_q + beats_total_q + 32'd1);
            last_d = next_last_c;
            keep_d = keep_for(cur_rem_q, next_last_c);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_dma_write_cmd.valid   = cmd_valid_q;
  assign m_axis_dma_write_cmd.address = cmd_addr_q;
  assign m_axis_dma_write_cmd.length  = cmd_len_q;
  assign m_axis_dma_write_data.valid  = data_valid_q;
  assign m_axis_dma_write_data.data   = data_q;
  assign m_axis_dma_write_data.keep   = keep_q;
  assign m_axis_dma_write_data.last   = last_q;

  // Status word map; unused words read as zero.
  always_comb begin
    status_reg    = '0;
    status_reg[0] = {30'd0, done_q, busy_q};
    status_reg[1] = cmds_q;
    status_reg[2] = beats_total_q;
    status_reg[3] = elapsed_q;
  end

endmodule
